// File: rtl/encoder_4x2_seq.sv
// ---------------------------------------------------------------------------
// encoder_4x2_seq
//
// Registered 4-to-2 priority encoder for the receiving side of a decoded,
// active-low select bus. Each falling edge on a select line, while capture
// is enabled, becomes a pending request. Pending requests are handed to the
// consumer one at a time as a two-bit index over a valid/ack handshake,
// lowest line index first. Strobes that arrive while an earlier request is
// still waiting are kept, not lost.
//
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   rst      - synchronous, active-high reset
//   D[0:3]   - active-low select lines (D[i]=0 means line i asserted)
//   enable   - active-low capture enable
//   ack      - consumer accepts the current code when valid && ack
//   A        - code bit 1 (registered)
//   B        - code bit 0 (registered)
//   valid    - {A,B} holds a code the consumer has not taken yet
//   pend     - per-line pending-request flags (registered, active-high)
//   overrun  - sticky; a line strobed again while its request still waited
// ---------------------------------------------------------------------------
module encoder_4x2_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic [0:3] D,
   input  logic       enable,
   input  logic       ack,
   output logic       A,
   output logic       B,
   output logic       valid,
   output logic [0:3] pend,
   output logic       overrun
);

   logic [0:3] line_hist;
   logic [0:3] strobe;
   logic [0:3] clear_vec;
   logic [0:3] pend_next;
   logic [0:3] overrun_hit;
   logic       slot_free;
   logic       has_pending;
   logic       do_load;
   logic [1:0] load_idx;
   logic       valid_next;
   logic [1:0] code_next;
   logic       overrun_next;

   // A strobe is a high-to-low transition seen between the previous sample
   // and the current input, qualified by the active-low enable. Because the
   // history register follows D every cycle, a line that fell while capture
   // was disabled already reads low in the history once enable drops, so it
   // can never be captured late.
   always_comb begin
      strobe = line_hist & ~D & {4{~enable}};
   end

   // Pick the lowest-numbered pending line. Scanning from the top down and
   // letting later hits overwrite earlier ones leaves the smallest index.
   // Only the pending state from before this edge is considered, so a strobe
   // that arrives on this edge waits one more cycle before it can be loaded.
   always_comb begin
      load_idx    = 2'd0;
      has_pending = |pend;
      for (int i = 3; i >= 0; i--) begin
         if (pend[i]) begin
            load_idx = 2'(i);
         end
      end
   end

   // The output slot can take a new code when it is empty, or when the
   // consumer is retiring the current one on this same edge. Allowing the
   // load on the ack edge gives one code per cycle with no bubble.
   always_comb begin
      slot_free = ~valid | ack;
      do_load   = slot_free & has_pending;
   end

   // Work out the next pending vector and the overrun condition. The line
   // being loaded is cleared first and new strobes are OR-ed in afterwards,
   // so a line that is handed out and re-strobed on the same edge stays
   // pending exactly once and does not count as an overrun. A strobe on a
   // line that stays pending is an overrun; the request is not duplicated.
   always_comb begin
      clear_vec = '0;
      if (do_load) begin
         clear_vec[load_idx] = 1'b1;
      end
      overrun_hit  = strobe & pend & ~clear_vec;
      pend_next    = (pend & ~clear_vec) | strobe;
      overrun_next = overrun | (|overrun_hit);
   end

   // Decide what the output slot holds after this edge. With a free slot
   // the next code is loaded if anything is pending, otherwise valid drops
   // and the last code is left on {A,B}. With a busy slot everything holds.
   always_comb begin
      valid_next = valid;
      code_next  = {A, B};
      if (slot_free) begin
         valid_next = has_pending;
         if (has_pending) begin
            code_next = load_idx;
         end
      end
   end

   // State register. Reset wins over everything, including a handshake in
   // progress: the in-flight code and all pending requests are dropped. The
   // history is forced high during reset so that a line already low when
   // reset is released strobes on the first edge afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_hist <= 4'b1111;
         pend      <= 4'b0000;
         A         <= 1'b0;
         B         <= 1'b0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         line_hist <= D;
         pend      <= pend_next;
         A         <= code_next[1];
         B         <= code_next[0];
         valid     <= valid_next;
         overrun   <= overrun_next;
      end
   end

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// ---------------------------------------------------------------------------
// tb_encoder_4x2_seq
//
// Self-checking bench for encoder_4x2_seq. A behavioural model tracks the
// pending requests as a plain array and the output slot as an integer code,
// and a compare process checks every cycle against it. Directed scenarios
// drive the select lines and pin both the DUT and the model with literal
// expectations, and a per-line count of retired codes confirms that each
// request is handed out exactly as often as it should be.
// ---------------------------------------------------------------------------
module tb_encoder_4x2_seq;

   logic       clk;
   logic       rst;
   logic [0:3] d_in;
   logic       enable;
   logic       ack;
   logic       a_out;
   logic       b_out;
   logic       valid;
   logic [0:3] pend;
   logic       overrun;

   int total;
   int bad;

   bit mp[4];
   bit mhist[4];
   bit mvalid;
   bit movr;
   int mcode;
   bit model_ready;

   int dut_ret[4];
   int mod_ret[4];

   encoder_4x2_seq dut (
      .clk     (clk),
      .rst     (rst),
      .D       (d_in),
      .enable  (enable),
      .ack     (ack),
      .A       (a_out),
      .B       (b_out),
      .valid   (valid),
      .pend    (pend),
      .overrun (overrun)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] dutVec();
      return {a_out, b_out, valid, pend, overrun};
   endfunction

   function automatic logic [7:0] modelVec();
      return {2'(mcode), mvalid, mp[0], mp[1], mp[2], mp[3], movr};
   endfunction

   // Behavioural model: hand out the lowest pending line whenever the slot
   // is empty or being acknowledged, then register any new falling edges.
   // Retired codes are tallied per line for both the model and the DUT.
   always @(posedge clk) begin
      int  pick;
      bit  free;
      bit  stb;
      if (valid === 1'b1 && ack === 1'b1) begin
         dut_ret[int'({a_out, b_out})]++;
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            mp[i]    = 1'b0;
            mhist[i] = 1'b1;
         end
         mvalid      = 1'b0;
         movr        = 1'b0;
         mcode       = 0;
         model_ready = 1'b1;
      end else begin
         if (mvalid && ack) begin
            mod_ret[mcode]++;
         end
         free = !mvalid || ack;
         pick = -1;
         for (int i = 0; i < 4; i++) begin
            if (pick < 0 && mp[i]) pick = i;
         end
         if (free) begin
            if (pick >= 0) begin
               mcode     = pick;
               mvalid    = 1'b1;
               mp[pick]  = 1'b0;
            end else begin
               mvalid = 1'b0;
            end
         end
         for (int i = 0; i < 4; i++) begin
            stb = mhist[i] && !d_in[i] && !enable;
            if (stb) begin
               if (mp[i]) movr = 1'b1;
               mp[i] = 1'b1;
            end
            mhist[i] = d_in[i];
         end
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model, away from the
   // rising edge.
   always @(negedge clk) begin
      if (model_ready) begin
         total++;
         if (dutVec() !== modelVec()) begin
            bad++;
            $display("[TB] FAIL cycle_compare at %0t: got %b expected %b",
                     $time, dutVec(), modelVec());
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic [0:3] d,
                                input logic en, input logic ak);
      @(negedge clk);
      rst    = r;
      d_in   = d;
      enable = en;
      ack    = ak;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] exp);
      total++;
      if (dutVec() !== exp) begin
         bad++;
         $display("[TB] FAIL %s (dut): got %b expected %b", name, dutVec(), exp);
      end
      total++;
      if (modelVec() !== exp) begin
         bad++;
         $display("[TB] FAIL %s (model): got %b expected %b", name, modelVec(), exp);
      end
   endtask

   task automatic checkCount(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      int r1;
      int r2;
      int m1;
      total       = 0;
      bad         = 0;
      model_ready = 1'b0;
      rst         = 1'b1;
      d_in        = 4'b0000;
      enable      = 1'b0;
      ack         = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dut_ret[i] = 0;
         mod_ret[i] = 0;
      end

      $display("[TB] reset with all lines low");
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput("reset", 8'b00_0_0000_0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("release_capture", 8'b00_0_1111_0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("first_load", 8'b00_1_0111_0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      checkOutput("drain_1", 8'b01_1_0011_0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      checkOutput("drain_2", 8'b10_1_0001_0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      checkOutput("drain_3", 8'b11_1_0000_0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      checkOutput("drain_empty", 8'b11_0_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);

      $display("[TB] single strobe on line 1");
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      checkOutput("single_capture", 8'b11_0_0100_0);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      checkOutput("single_load", 8'b01_1_0000_0);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      checkOutput("single_hold", 8'b01_1_0000_0);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b1);
      checkOutput("single_ack", 8'b01_0_0000_0);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      checkOutput("held_low_no_repeat", 8'b01_0_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);

      $display("[TB] priority and drain, lines 0 and 3");
      applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1);
      checkOutput("prio_capture", 8'b01_0_1001_0);
      applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1);
      checkOutput("prio_first", 8'b00_1_0001_0);
      applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1);
      checkOutput("prio_second", 8'b11_1_0000_0);
      applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1);
      checkOutput("prio_empty", 8'b11_0_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);

      $display("[TB] enable gating on line 2");
      applyStimulus(1'b0, 4'b1101, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
      checkOutput("enable_gated", 8'b11_0_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
      checkOutput("enable_capture", 8'b11_0_0010_0);
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
      checkOutput("enable_code", 8'b10_1_0000_0);
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);

      $display("[TB] overrun on line 1 with busy slot");
      applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      checkOutput("busy_slot", 8'b00_1_0000_0);
      r1 = dut_ret[1];
      m1 = mod_ret[1];
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      checkOutput("overrun_first", 8'b00_1_0100_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
      checkOutput("overrun_set", 8'b00_1_0100_1);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
      checkOutput("overrun_load", 8'b01_1_0000_1);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      checkOutput("overrun_sticky", 8'b01_0_0000_1);
      checkCount("overrun_one_code_dut", dut_ret[1] - r1, 1);
      checkCount("overrun_one_code_model", mod_ret[1] - m1, 1);
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
      checkOutput("overrun_reset", 8'b00_0_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);

      $display("[TB] reload collision on line 2");
      applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      r2 = dut_ret[2];
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
      checkOutput("reclear_pending", 8'b00_1_0010_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1101, 1'b0, 1'b1);
      checkOutput("reclear_load", 8'b10_1_0010_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      checkOutput("reclear_hold", 8'b10_1_0010_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
      checkOutput("reclear_second", 8'b10_1_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
      checkOutput("reclear_empty", 8'b10_0_0000_0);
      checkCount("reclear_two_codes", dut_ret[2] - r2, 2);

      $display("[TB] reset during a pending handshake");
      applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      checkOutput("midflight_busy", 8'b00_1_0100_0);
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
      checkOutput("midflight_reset", 8'b00_0_0000_0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
